unidade_controle_jogada: RTL and testbench

//  Control unit (Moore FSM) sequencing the play datapath: address counter, key register,
//  16x4 memory and comparator. Waits for a player move, registers the keys, compares them

---
 rtl/unidade_controle_jogada.sv | 158 +++++++++++++++
 tb/tb_unidade_controle_jogada.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogada.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogada
//
// Moore control unit for the play datapath: address counter, key register,
// 16x4 memory and comparator. It waits for a player move, loads the key
// register, checks the comparator and then either advances the address or
// ends the round. A round ends in a hit, a miss or a timeout.
//
// Parameters
//   TIMEOUT_CICLOS : clock cycles allowed in ESPERA before timeout (>= 2)
//
// Ports
//   clock        in   rising-edge system clock
//   reset        in   asynchronous active-high reset -> INICIAL, timer cleared
//   iniciar      in   start / restart request
//   jogada       in   one-cycle pulse: a key was pressed
//   igual        in   registered keys equal the memory word at current address
//   fim_contagem in   address counter is at its last address
//   zera_c       out  clear address counter
//   conta_c      out  increment address counter
//   zera_r       out  clear key register
//   registra_r   out  load key register
//   pronto       out  round finished (any end state)
//   acertou      out  all words matched
//   errou        out  mismatch or timeout
//   timeout      out  round ended by timeout
//   db_estado    out  current state code, for the 7-segment debug display
// -----------------------------------------------------------------------------
module unidade_controle_jogada #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_contagem,
    output logic       zera_c,
    output logic       conta_c,
    output logic       zera_r,
    output logic       registra_r,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int TW = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS - 1);

    // The encodings double as the debug display codes.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    estado_t        estado_reg, estado_next;
    logic [TW-1:0]  timer_reg, timer_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg <= INICIAL;
            timer_reg  <= '0;
        end else begin
            estado_reg <= estado_next;
            timer_reg  <= timer_next;
        end
    end

    // Timer only runs while waiting for a move; it saturates at LIMITE so it
    // can never wrap, although the FSM leaves ESPERA on that same edge.
    always_comb begin
        timer_next = '0;
        if (estado_reg == ESPERA) begin
            if (timer_reg != LIMITE) begin
                timer_next = timer_reg + TW'(1);
            end else begin
                timer_next = timer_reg;
            end
        end
    end

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            INICIAL:     if (iniciar) estado_next = PREPARACAO;
            PREPARACAO:  estado_next = ESPERA;
            ESPERA: begin
                // A move on the last allowed cycle still counts.
                if (jogada) begin
                    estado_next = REGISTRA;
                end else if (timer_reg == LIMITE) begin
                    estado_next = FIM_TIMEOUT;
                end
            end
            REGISTRA:    estado_next = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    estado_next = FIM_ERRO;
                end else if (fim_contagem) begin
                    estado_next = FIM_ACERTO;
                end else begin
                    estado_next = PROXIMO;
                end
            end
            PROXIMO:     estado_next = ESPERA;
            FIM_ACERTO,
            FIM_TIMEOUT,
            FIM_ERRO:    if (iniciar) estado_next = PREPARACAO;
            default:     estado_next = INICIAL;
        endcase
    end

    // Outputs depend on the state register only, so reset clears them at once.
    always_comb begin
        zera_c     = 1'b0;
        conta_c    = 1'b0;
        zera_r     = 1'b0;
        registra_r = 1'b0;
        pronto     = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        timeout    = 1'b0;
        case (estado_reg)
            PREPARACAO: begin
                zera_c = 1'b1;
                zera_r = 1'b1;
            end
            REGISTRA:   registra_r = 1'b1;
            PROXIMO:    conta_c    = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_reg;

endmodule

// File: tb/tb_unidade_controle_jogada.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle_jogada
//
// Plays whole rounds against the control unit. For each round the driver
// works out, from the game rules alone, how it must end (hit / miss /
// timeout), on which clock edge it ends and how many counter, register and
// clear pulses it takes, and queues that record. A monitor counts the pulses
// the DUT really produces and, when pronto rises, pops and compares.
// -----------------------------------------------------------------------------
module tb_unidade_controle_jogada;

    localparam int TO = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar, jogada, igual, fim_contagem;
    logic       zera_c, conta_c, zera_r, registra_r;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int games  = 0;

    typedef struct {
        int         fim;
        logic [3:0] est;
        int         contas;
        int         regs;
    } exp_t;

    exp_t sb[$];

    unidade_controle_jogada #(.TIMEOUT_CICLOS(TO)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fim_contagem(fim_contagem), .zera_c(zera_c),
        .conta_c(conta_c), .zera_r(zera_r), .registra_r(registra_r),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   n_conta = 0, n_reg = 0, n_zera = 0;
    logic pronto_prev = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            n_conta = 0; n_reg = 0; n_zera = 0;
            pronto_prev = 1'b0;
        end else begin
            if (conta_c)    n_conta++;
            if (registra_r) n_reg++;
            if (zera_c && zera_r) n_zera++;
            if (pronto && !pronto_prev) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_end", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("end_cycle", cyc, e.fim);
                    chk("end_state", int'(db_estado), int'(e.est));
                    chk("acertou", int'(acertou), int'(e.est == 4'hA));
                    chk("errou", int'(errou), int'(e.est != 4'hA));
                    chk("timeout", int'(timeout), int'(e.est == 4'hD));
                    chk("conta_pulses", n_conta, e.contas);
                    chk("registra_pulses", n_reg, e.regs);
                    chk("zera_pulses", n_zera, 1);
                    $display("game %0d: end=%h cycle=%0d conta=%0d registra=%0d",
                             games, db_estado, cyc, n_conta, n_reg);
                    games++;
                end
                n_conta = 0; n_reg = 0; n_zera = 0;
            end
            pronto_prev = pronto;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits w cycles in ESPERA with noise on inputs the FSM must ignore there.
    task automatic wait_esp(input int w);
        for (int i = 0; i < w; i++) begin
            iniciar      = 1'($urandom_range(0, 1));
            igual        = 1'($urandom_range(0, 1));
            fim_contagem = 1'($urandom_range(0, 1));
            tick();
        end
        iniciar = 1'b0;
    endtask

    task automatic start_game(output int m, input bit t2);
        iniciar = 1'b1;
        jogada  = 1'b0;
        m = cyc;
        tick();
        iniciar = 1'b0;
        if (t2) begin
            chk("t2_prep_state", int'(db_estado), 1);
            chk("t2_zera_c_on", int'(zera_c), 1);
            chk("t2_zera_r_on", int'(zera_r), 1);
        end
        tick();
        if (t2) begin
            chk("t2_espera_state", int'(db_estado), 2);
            chk("t2_zera_c_off", int'(zera_c), 0);
            chk("t2_zera_r_off", int'(zera_r), 0);
        end
    endtask

    // One move: wait w cycles, pulse jogada, hold igual/fim through compare.
    // Stray jogada pulses in COMPARACAO and PROXIMO must be ignored.
    task automatic move(input int w, input bit g, input bit f, input bit last);
        wait_esp(w);
        jogada = 1'b1; igual = g; fim_contagem = f;
        tick();
        jogada = 1'b0;
        tick();
        jogada = 1'($urandom_range(0, 1));
        tick();
        jogada = 1'b0;
        if (!last) begin
            jogada = 1'($urandom_range(0, 1));
            tick();
            jogada = 1'b0;
        end
    endtask

    // gtype 0: 16 correct moves; 1: miss on move k; 2: timeout instead of move k.
    task automatic play(input int gtype, input int k, input bit fixed_w, input bit t2);
        int   ws[16];
        int   cost, m, nmoves;
        exp_t e;
        bit   last, g, f;
        cost = 0;
        for (int i = 0; i < 16; i++) ws[i] = fixed_w ? TO - 1 : int'($urandom_range(0, TO - 1));
        nmoves = (gtype == 0) ? 16 : ((gtype == 1) ? k : k - 1);
        // Each move: wait, then the jogada edge, REGISTRA, COMPARACAO, and PROXIMO
        // unless it ends the round; a timeout costs TO edges in ESPERA.
        for (int i = 0; i < nmoves; i++) begin
            last = (i == nmoves - 1) && (gtype != 2);
            cost += ws[i] + 1 + (last ? 2 : 3);
        end
        if (gtype == 2) cost += TO;
        e.est    = (gtype == 0) ? 4'hA : ((gtype == 1) ? 4'hE : 4'hD);
        e.contas = (gtype == 0) ? 15 : k - 1;
        e.regs   = nmoves;
        start_game(m, t2);
        e.fim = m + 2 + cost;
        sb.push_back(e);
        for (int i = 0; i < nmoves; i++) begin
            last = (i == nmoves - 1) && (gtype != 2);
            g = !(gtype == 1 && i == k - 1);
            f = (gtype == 0 && i == 15) ||
                (gtype == 1 && i == k - 1 && $urandom_range(0, 1) == 1);
            move(ws[i], g, f, last);
        end
        if (gtype == 2) wait_esp(TO);
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick();
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int m;
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fim_contagem = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", int'(db_estado), 0);
        chk("reset_outputs", int'({zera_c, conta_c, zera_r, registra_r,
                                   pronto, acertou, errou, timeout}), 0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        // idle in INICIAL: jogada must be ignored
        jogada = 1'b1; tick(); jogada = 1'b0; tick();
        chk("idle_inicial", int'(db_estado), 0);

        play(1, 3, 1'b0, 1'b1);   // miss on 3rd move, with start-up checks
        play(0, 0, 1'b1, 1'b0);   // restart from FIM_ERRO, every move on the last cycle
        play(2, 1, 1'b0, 1'b0);   // timeout in the very first wait

        // Asynchronous reset in the middle of ESPERA
        start_game(m, 1'b0);
        move(2, 1'b1, 1'b0, 1'b0);
        wait_esp(3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_state", int'(db_estado), 0);
        chk("async_reset_outputs", int'({zera_c, conta_c, zera_r, registra_r,
                                         pronto, acertou, errou, timeout}), 0);
        @(negedge clock);
        #2;
        reset = 1'b0;
        tick();
        chk("after_reset_state", int'(db_estado), 0);
        play(2, 2, 1'b0, 1'b0);   // timer must restart from zero after reset

        for (int n = 0; n < 20; n++) begin
            int gt;
            gt = int'($urandom_range(0, 2));
            play(gt, int'($urandom_range(1, 16)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
